// File: rtl/vga_pkg.sv
// Shared timing defaults, pixel/address packing and the per-pixel control
// bundle that rides the alignment delay line.
package vga_pkg;

    // 640x480@60 with a 25 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_IMG_X0   = 192;
    localparam int DEF_IMG_Y0   = 112;
    localparam int IMG_SIZE     = 256;
    localparam int CNT_W        = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
    } fb_addr_t;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic inwin;
        logic first;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1,
                                      inwin: 1'b0, first: 1'b0};

    function automatic fb_addr_t fb_pack(input logic [7:0] y, input logic [7:0] x);
        fb_pack = '{y: y, x: x};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with wrap logic and the stage-0 active/sync decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             CLK,
    input  logic             NRST,
    output logic [CNT_W-1:0] o_hc,
    output logic [CNT_W-1:0] o_vc,
    output logic             o_active,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_first
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;
    logic             w_h_end;
    logic             w_v_end;

    assign w_h_end = (r_hc == CNT_W'(H_TOTAL - 1));
    assign w_v_end = (r_vc == CNT_W'(V_TOTAL - 1));

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_h_end) begin
            r_hc <= '0;
            r_vc <= w_v_end ? '0 : r_vc + CNT_W'(1);
        end else begin
            r_hc <= r_hc + CNT_W'(1);
        end
    end

    assign o_hc     = r_hc;
    assign o_vc     = r_vc;
    assign o_active = (r_hc < CNT_W'(H_ACTIVE)) && (r_vc < CNT_W'(V_ACTIVE));
    assign o_hs     = !((r_hc >= CNT_W'(H_ACTIVE + H_FP)) &&
                        (r_hc <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vs     = !((r_vc >= CNT_W'(V_ACTIVE + V_FP)) &&
                        (r_vc <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_first  = (r_hc == '0) && (r_vc == '0);

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer reader: window test, read issue, RAM-latency alignment and
// the registered VGA output mux.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int IMG_X0   = DEF_IMG_X0,
    parameter int IMG_Y0   = DEF_IMG_Y0,
    parameter int RAM_LAT  = 1
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic [23:0] iBORDER,
    output logic        oRD_EN,
    output logic [15:0] oRD_ADDR,
    input  logic [23:0] iRD_DATA,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_N,
    output logic        oFRAME_START
);

    logic [CNT_W-1:0] w_hc;
    logic [CNT_W-1:0] w_vc;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic             w_first;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .CLK      (CLK),
        .NRST     (NRST),
        .o_hc     (w_hc),
        .o_vc     (w_vc),
        .o_active (w_active),
        .o_hs     (w_hs),
        .o_vs     (w_vs),
        .o_first  (w_first)
    );

    // Unsigned 10-bit offsets: columns/lines left of or above the window
    // wrap to large values and fail the < 256 test.
    logic [CNT_W-1:0] w_dx;
    logic [CNT_W-1:0] w_dy;
    logic             w_inwin;
    stage_t           w_stage;

    assign w_dx    = w_hc - CNT_W'(IMG_X0);
    assign w_dy    = w_vc - CNT_W'(IMG_Y0);
    assign w_inwin = w_active && (w_dx < CNT_W'(IMG_SIZE)) && (w_dy < CNT_W'(IMG_SIZE));

    always_comb begin
        w_stage        = STAGE_IDLE;
        w_stage.active = w_active;
        w_stage.hs     = w_hs;
        w_stage.vs     = w_vs;
        w_stage.inwin  = w_inwin;
        w_stage.first  = w_first;
    end

    logic     r_rd_en;
    fb_addr_t r_rd_addr;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_en <= w_inwin;
            if (w_inwin)
                r_rd_addr <= fb_pack(w_dy[7:0], w_dx[7:0]);
        end
    end

    assign oRD_EN   = r_rd_en;
    assign oRD_ADDR = r_rd_addr;

    // Stage k holds the controls issued k+1 cycles ago; stage RAM_LAT lines
    // up with the read data returned for the same pixel.
    stage_t [RAM_LAT:0] r_pipe;

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_pipe <= {(RAM_LAT + 1){STAGE_IDLE}};
        end else begin
            r_pipe[0] <= w_stage;
            for (int k = 1; k <= RAM_LAT; k++)
                r_pipe[k] <= r_pipe[k-1];
        end
    end

    stage_t w_al;
    rgb24_t w_rgb_next;
    rgb24_t r_rgb;
    logic   r_hs;
    logic   r_vs;
    logic   r_blank_n;
    logic   r_frame_start;

    assign w_al = r_pipe[RAM_LAT];

    always_comb begin
        w_rgb_next = '0;
        if (w_al.inwin)
            w_rgb_next = iRD_DATA;
        else if (w_al.active)
            w_rgb_next = iBORDER;
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            r_rgb         <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_rgb_next;
            r_hs          <= w_al.hs;
            r_vs          <= w_al.vs;
            r_blank_n     <= w_al.active;
            r_frame_start <= w_al.first;
        end
    end

    assign oVGA_R       = r_rgb.r;
    assign oVGA_G       = r_rgb.g;
    assign oVGA_B       = r_rgb.b;
    assign oVGA_HS      = r_hs;
    assign oVGA_VS      = r_vs;
    assign oVGA_BLANK_N = r_blank_n;
    assign oFRAME_START = r_frame_start;

endmodule
